// File: rtl/sha256_msg_padder.sv
// SHA-256 message front end: packs input beats into a 64-byte block, applies the padding, and streams 16 big-endian words.
// Optional macro SHA256_PAD_ERR_EN adds a sticky pad_error output for malformed beats and length overflow.
module sha256_msg_padder #(
    parameter int IN_BYTES  = 1,
    parameter int LEN_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_enable,
    output logic                  load_ready,
    input  logic [8*IN_BYTES-1:0] input_data,
    input  logic [2:0]            input_valid_bytes,
    input  logic                  input_complete,
    output logic [31:0]           block_word,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [3:0]            word_index,
    output logic                  block_last,
`ifdef SHA256_PAD_ERR_EN
    output logic                  pad_error,
`endif
    output logic                  busy
);

    typedef enum logic [2:0] {ACCEPT, PAD, EMIT, LENBLK, DONE} state_t;

    localparam logic [2:0] IN_B = 3'(IN_BYTES);

    state_t               state;
    state_t               state_next;
    logic [7:0]           buffer   [64];
    logic [7:0]           buf_next [64];
    logic [6:0]           ptr;
    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] count_next;
    logic                 more_data;
    logic                 final_blk;
    logic                 pad_pending;
    logic                 busy_r;
    logic [3:0]           word_idx;
    logic                 beat_fire;
    logic                 word_fire;
    logic [2:0]           beat_bytes;
    logic [6:0]           fill_sum;
    logic [63:0]          bit_length;

    assign beat_fire  = load_ready && load_enable;
    assign word_fire  = word_valid && word_ready;
    assign beat_bytes = (input_valid_bytes > IN_B) ? IN_B : input_valid_bytes;
    assign fill_sum   = ptr + 7'(beat_bytes);
    assign count_next = count + LEN_WIDTH'(beat_bytes);
    assign bit_length = 64'({count, 3'b000});
    assign busy       = busy_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // A final beat that exactly fills the block still emits that data block first; pad_pending then routes to PAD.
    always_comb begin
        state_next = state;
        case (state)
            ACCEPT: begin
                if (beat_fire) begin
                    if (fill_sum >= 7'd64) begin
                        state_next = EMIT;
                    end else if (input_complete) begin
                        state_next = PAD;
                    end
                end
            end
            PAD:    state_next = EMIT;
            EMIT: begin
                if (word_fire && word_idx == 4'd15) begin
                    if (more_data) begin
                        state_next = pad_pending ? PAD : ACCEPT;
                    end else if (final_blk) begin
                        state_next = DONE;
                    end else begin
                        state_next = LENBLK;
                    end
                end
            end
            LENBLK: state_next = EMIT;
            DONE:   state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        word_valid = 1'b0;
        block_word = 32'd0;
        word_index = 4'd0;
        block_last = 1'b0;
        case (state)
            ACCEPT: load_ready = 1'b1;
            EMIT: begin
                word_valid = 1'b1;
                block_word = {buffer[{word_idx, 2'd0}], buffer[{word_idx, 2'd1}],
                              buffer[{word_idx, 2'd2}], buffer[{word_idx, 2'd3}]};
                word_index = word_idx;
                block_last = final_blk && !more_data && (word_idx == 4'd15);
            end
            default: ;
        endcase
    end

    // Next buffer image: beat bytes at the fill pointer, the 0x80/zero/length pad, or a length-only block.
    always_comb begin
        for (int j = 0; j < 64; j++) begin
            buf_next[j] = buffer[j];
        end
        case (state)
            ACCEPT: begin
                if (beat_fire) begin
                    for (int i = 0; i < IN_BYTES; i++) begin
                        if (3'(i) < beat_bytes && (ptr + 7'(i)) < 7'd64) begin
                            buf_next[6'(ptr + 7'(i))] = input_data[8*(IN_BYTES-1-i) +: 8];
                        end
                    end
                end
            end
            PAD: begin
                for (int j = 0; j < 64; j++) begin
                    if (7'(j) == ptr) begin
                        buf_next[j] = 8'h80;
                    end else if (7'(j) > ptr) begin
                        buf_next[j] = 8'h00;
                    end
                end
                if (ptr <= 7'd55) begin
                    for (int k = 0; k < 8; k++) begin
                        buf_next[56+k] = bit_length[63-8*k -: 8];
                    end
                end
            end
            LENBLK: begin
                for (int j = 0; j < 56; j++) begin
                    buf_next[j] = 8'h00;
                end
                for (int k = 0; k < 8; k++) begin
                    buf_next[56+k] = bit_length[63-8*k -: 8];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < 64; j++) begin
                buffer[j] <= 8'h00;
            end
        end else begin
            for (int j = 0; j < 64; j++) begin
                buffer[j] <= buf_next[j];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr         <= 7'd0;
            count       <= '0;
            more_data   <= 1'b0;
            final_blk   <= 1'b0;
            pad_pending <= 1'b0;
            word_idx    <= 4'd0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (beat_fire) begin
                        busy_r <= 1'b1;
                        count  <= count_next;
                        if (fill_sum >= 7'd64) begin
                            ptr         <= 7'd64;
                            more_data   <= 1'b1;
                            pad_pending <= input_complete;
                        end else begin
                            ptr <= fill_sum;
                        end
                    end
                end
                PAD: begin
                    final_blk <= (ptr <= 7'd55);
                    word_idx  <= 4'd0;
                end
                EMIT: begin
                    if (word_fire) begin
                        word_idx <= word_idx + 4'd1;
                        if (word_idx == 4'd15) begin
                            if (more_data) begin
                                more_data   <= 1'b0;
                                pad_pending <= 1'b0;
                                ptr         <= 7'd0;
                            end else if (final_blk) begin
                                busy_r <= 1'b0;
                            end
                        end
                    end
                end
                LENBLK: final_blk <= 1'b1;
                DONE: begin
                    count     <= '0;
                    ptr       <= 7'd0;
                    final_blk <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA256_PAD_ERR_EN
    logic count_wrap;
    assign count_wrap = (count_next < count);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pad_error <= 1'b0;
        end else if (beat_fire && ((input_valid_bytes > IN_B) ||
                                   (!input_complete && input_valid_bytes < IN_B) ||
                                   count_wrap)) begin
            pad_error <= 1'b1;
        end
    end
`endif

endmodule
